fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC0_0000, first fetch address after reset.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port ireq_valid  out  1  instruction-memory request valid.
REQ-005 SHALL have port ireq_addr  out  32  request address (word aligned).
REQ-006 SHALL have port ireq_ready  in  1  memory accepts request this cycle (addr_ok).
REQ-007 SHALL have port iresp_valid  in  1  instruction data returned this cycle (data_ok).
REQ-008 SHALL have port iresp_data  in  32  returned instruction word.
REQ-009 SHALL have port stall  in  1  decode/hazard unit holds the F->D register.
REQ-010 SHALL have port redir_valid  in  1  redirect (taken BEQ/BNE, JAL) from decode.
REQ-011 SHALL have port redir_pc  in  32  redirect target.
REQ-012 SHALL have ports d_valid/d_pc/d_instr/d_valP/d_exc  out  1/32/32/32/1  registered F->D outputs; d_valP = d_pc+4; d_exc = misaligned fetch.

Function
REQ-013 SHALL hold fetch PC register pc and at most one outstanding memory request.
REQ-014 SHALL implement states S_REQ, S_WAIT, S_HOLD, S_DROP.
REQ-015 S_REQ: ireq_valid=1, ireq_addr=pc unless redir_valid=1 or pc[1:0]!=0; ireq_ready=1 -> S_WAIT.
REQ-016 S_REQ with redir_valid=1: ireq_valid=0, pc<=redir_pc, stay S_REQ.
REQ-017 S_REQ with pc[1:0]!=0 and stall=0: no request; d_valid<=1, d_exc<=1, d_instr<=0, d_pc<=pc; pc<=pc+4; stay S_REQ.
REQ-018 S_WAIT, iresp_valid=1, stall=0, redir_valid=0: d_valid<=1, d_pc<=pc, d_instr<=iresp_data, d_valP<=pc+4, d_exc<=0; pc<=pc+4; -> S_REQ.
REQ-019 S_WAIT, iresp_valid=1, stall=1: capture data in internal hold buffer; -> S_HOLD; d_* unchanged.
REQ-020 S_WAIT, redir_valid=1, iresp_valid=0: pc<=redir_pc; -> S_DROP.
REQ-021 S_WAIT, redir_valid=1 and iresp_valid=1 same cycle: discard response; pc<=redir_pc; -> S_REQ.
REQ-022 S_DROP: ireq_valid=0; iresp_valid=1 -> discard, -> S_REQ; redir_valid=1 -> pc<=redir_pc, stay unless response also arrives.
REQ-023 S_HOLD: stall=0 -> load d_* from hold buffer, pc<=pc+4, -> S_REQ; redir_valid=1 -> drop buffer, pc<=redir_pc, -> S_REQ (redirect wins).
REQ-024 redir_valid=1 SHALL clear d_valid on the next edge (flush), regardless of stall; the redirected instruction is never produced before that edge.
REQ-025 stall=1 and redir_valid=0 SHALL keep d_* unchanged.
REQ-026 d_valid SHALL drop to 0 on any edge where no new instruction is loaded and stall=0.
REQ-027 pc arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-028 Latency: response accepted at edge t -> d_valid=1 after edge t; throughput at most one instruction per two cycles.
REQ-029 ireq_addr SHALL stay stable while ireq_valid=1 and ireq_ready=0.

Reset
REQ-030 reset=1 SHALL immediately force pc=RESET_PC, state=S_REQ, d_valid=0, d_pc=0, d_instr=0, d_valP=0, d_exc=0, hold buffer empty.
REQ-031 reset asserted mid-request SHALL abandon the outstanding request; any iresp_valid arriving after reset release without a post-reset request SHALL be ignored.
REQ-032 ireq_valid SHALL be 0 while reset=1 and SHALL assert in the first cycle after release.

Verification
REQ-033 Reset release, ireq_ready=1, response next cycle with 32'h2408_0005 -> ireq_addr=32'hBFC0_0000, then d_valid=1, d_pc=32'hBFC0_0000, d_valP=32'hBFC0_0004.
REQ-034 stall=1 held 3 cycles during response 32'h0000_0000 -> S_HOLD, d_* unchanged; stall drop -> buffered word appears once, next ireq_addr = pc+4.
REQ-035 redir_valid=1, redir_pc=32'hBFC0_0100 while in S_WAIT; response arrives two cycles later -> response discarded, next ireq_addr=32'hBFC0_0100, d_valid=0 after redirect edge.
REQ-036 redir_valid and iresp_valid same cycle -> no d_valid for the response; next request to redir_pc.
REQ-037 redir_pc=32'hBFC0_0102 -> no memory request; d_valid=1, d_exc=1, d_instr=0, d_pc=32'hBFC0_0102.
REQ-038 ireq_ready=0 for 4 cycles -> ireq_valid and ireq_addr stable; reset asserted in cycle 2 -> outputs cleared immediately, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding request, redirect/flush handling,
// stall hold buffer and registered F->D outputs.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_valP,
  output logic        d_exc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nx;
  logic [31:0] r_hold;
  logic [31:0] w_hold_nx;
  logic [31:0] w_pc_inc;
  logic [31:0] w_ld_instr;
  logic        w_load;
  logic        w_ld_exc;
  logic        w_misal;

  assign w_pc_inc  = r_pc + 32'd4;
  assign w_misal   = (r_pc[1:0] != 2'b00);
  assign ireq_addr = r_pc;

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_hold_nx  = r_hold;
    w_load     = 1'b0;
    w_ld_exc   = 1'b0;
    w_ld_instr = 32'h0;
    ireq_valid = 1'b0;
    case (r_state)
      S_REQ: begin
        if (redir_valid) begin
          w_pc_nx = redir_pc;
        end else if (w_misal) begin
          // Misaligned PC never reaches memory; it becomes an exception slot.
          if (!stall) begin
            w_load   = 1'b1;
            w_ld_exc = 1'b1;
            w_pc_nx  = w_pc_inc;
          end
        end else begin
          ireq_valid = !reset;
          if (ireq_ready) w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redir_valid) begin
          w_pc_nx    = redir_pc;
          w_state_nx = iresp_valid ? S_REQ : S_DROP;
        end else if (iresp_valid) begin
          if (!stall) begin
            w_load     = 1'b1;
            w_ld_instr = iresp_data;
            w_pc_nx    = w_pc_inc;
            w_state_nx = S_REQ;
          end else begin
            w_hold_nx  = iresp_data;
            w_state_nx = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redir_valid) begin
          w_pc_nx    = redir_pc;
          w_state_nx = S_REQ;
        end else if (!stall) begin
          w_load     = 1'b1;
          w_ld_instr = r_hold;
          w_pc_nx    = w_pc_inc;
          w_state_nx = S_REQ;
        end
      end
      S_DROP: begin
        // Waiting out a response that belongs to the pre-redirect path.
        if (redir_valid) w_pc_nx = redir_pc;
        if (iresp_valid) w_state_nx = S_REQ;
      end
      default: w_state_nx = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_hold  <= 32'h0;
      d_valid <= 1'b0;
      d_pc    <= 32'h0;
      d_instr <= 32'h0;
      d_valP  <= 32'h0;
      d_exc   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_hold  <= w_hold_nx;
      if (w_load) begin
        d_valid <= 1'b1;
        d_pc    <= r_pc;
        d_instr <= w_ld_instr;
        d_valP  <= w_pc_inc;
        d_exc   <= w_ld_exc;
      end else if (redir_valid || !stall) begin
        d_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with hand-computed expected values.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic [31:0] d_valP;
  logic        d_exc;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data),
    .stall(stall), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .d_valid(d_valid), .d_pc(d_pc), .d_instr(d_instr), .d_valP(d_valP), .d_exc(d_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_d(input string tag, input logic v, input logic [31:0] pc,
                       input logic [31:0] ins, input logic [31:0] vp, input logic ex);
    chk({tag, ".d_valid"}, {31'h0, d_valid}, {31'h0, v});
    chk({tag, ".d_pc"},    d_pc, pc);
    chk({tag, ".d_instr"}, d_instr, ins);
    chk({tag, ".d_valP"},  d_valP, vp);
    chk({tag, ".d_exc"},   {31'h0, d_exc}, {31'h0, ex});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ireq_ready = 1'b0; iresp_valid = 1'b0; iresp_data = 32'h0;
    stall = 1'b0; redir_valid = 1'b0; redir_pc = 32'h0;
    tick(); tick();
    chk("rst.ireq_valid", {31'h0, ireq_valid}, 32'h0);
    chk_d("rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Basic fetch after reset release
    reset = 1'b0; ireq_ready = 1'b1; #1;
    chk("f1.ireq_valid", {31'h0, ireq_valid}, 32'h1);
    chk("f1.ireq_addr", ireq_addr, 32'hBFC0_0000);
    tick();
    ireq_ready = 1'b0; iresp_valid = 1'b1; iresp_data = 32'h2408_0005; #1;
    chk("f1.wait_noreq", {31'h0, ireq_valid}, 32'h0);
    tick();
    iresp_valid = 1'b0; #1;
    chk_d("f1", 1'b1, 32'hBFC0_0000, 32'h2408_0005, 32'hBFC0_0004, 1'b0);
    chk("f1.next_addr", ireq_addr, 32'hBFC0_0004);
    chk("f1.next_valid", {31'h0, ireq_valid}, 32'h1);
    tick();
    chk("f1.d_valid_drop", {31'h0, d_valid}, 32'h0);
    chk("f1.addr_stable", ireq_addr, 32'hBFC0_0004);

    // Stall during response -> hold buffer
    ireq_ready = 1'b1; tick();
    ireq_ready = 1'b0; stall = 1'b1; iresp_valid = 1'b1; iresp_data = 32'h0;
    tick();
    iresp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk_d("hold", 1'b0, 32'hBFC0_0000, 32'h2408_0005, 32'hBFC0_0004, 1'b0);
      chk("hold.noreq", {31'h0, ireq_valid}, 32'h0);
      tick();
    end
    chk_d("hold3", 1'b0, 32'hBFC0_0000, 32'h2408_0005, 32'hBFC0_0004, 1'b0);
    stall = 1'b0; tick();
    chk_d("unhold", 1'b1, 32'hBFC0_0004, 32'h0, 32'hBFC0_0008, 1'b0);
    chk("unhold.addr", ireq_addr, 32'hBFC0_0008);
    stall = 1'b1; tick();
    chk("stall.keep_valid", {31'h0, d_valid}, 32'h1);
    chk("stall.keep_pc", d_pc, 32'hBFC0_0004);

    // Redirect in S_WAIT under stall flushes; late response dropped
    ireq_ready = 1'b1; tick();
    chk("redir.pre_valid", {31'h0, d_valid}, 32'h1);
    ireq_ready = 1'b0; redir_valid = 1'b1; redir_pc = 32'hBFC0_0100;
    tick();
    redir_valid = 1'b0; stall = 1'b0; #1;
    chk("redir.flush", {31'h0, d_valid}, 32'h0);
    chk("redir.drop_noreq", {31'h0, ireq_valid}, 32'h0);
    tick();
    iresp_valid = 1'b1; iresp_data = 32'hDEAD_BEEF; tick();
    iresp_valid = 1'b0; #1;
    chk("redir.discard", {31'h0, d_valid}, 32'h0);
    chk("redir.req_valid", {31'h0, ireq_valid}, 32'h1);
    chk("redir.req_addr", ireq_addr, 32'hBFC0_0100);

    // Redirect and response in the same cycle
    ireq_ready = 1'b1; tick();
    ireq_ready = 1'b0; redir_valid = 1'b1; redir_pc = 32'hBFC0_0200;
    iresp_valid = 1'b1; iresp_data = 32'h1111_1111; tick();
    redir_valid = 1'b0; iresp_valid = 1'b0; #1;
    chk("same.d_valid", {31'h0, d_valid}, 32'h0);
    chk("same.req_valid", {31'h0, ireq_valid}, 32'h1);
    chk("same.req_addr", ireq_addr, 32'hBFC0_0200);

    // Misaligned redirect target
    redir_valid = 1'b1; redir_pc = 32'hBFC0_0102; #1;
    chk("mis.redir_noreq", {31'h0, ireq_valid}, 32'h0);
    tick();
    redir_valid = 1'b0; #1;
    chk("mis.noreq", {31'h0, ireq_valid}, 32'h0);
    tick();
    chk_d("mis", 1'b1, 32'hBFC0_0102, 32'h0, 32'hBFC0_0106, 1'b1);

    // PC wrap at top of address space
    redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC; tick();
    redir_valid = 1'b0; #1;
    chk("wrap.flush", {31'h0, d_valid}, 32'h0);
    chk("wrap.addr", ireq_addr, 32'hFFFF_FFFC);
    ireq_ready = 1'b1; tick();
    ireq_ready = 1'b0; iresp_valid = 1'b1; iresp_data = 32'hA5A5_A5A5; tick();
    iresp_valid = 1'b0; #1;
    chk_d("wrap", 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 32'h0, 1'b0);
    chk("wrap.next_addr", ireq_addr, 32'h0);

    // Request not accepted, then reset mid-request
    chk("nr.valid0", {31'h0, ireq_valid}, 32'h1);
    tick();
    chk("nr.valid1", {31'h0, ireq_valid}, 32'h1);
    chk("nr.addr1", ireq_addr, 32'h0);
    tick();
    reset = 1'b1; #1;
    chk("nr.rst_noreq", {31'h0, ireq_valid}, 32'h0);
    chk("nr.rst_addr", ireq_addr, 32'hBFC0_0000);
    chk_d("nr.rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    reset = 1'b0; iresp_valid = 1'b1; iresp_data = 32'h7777_7777; #1;
    chk("nr.restart_valid", {31'h0, ireq_valid}, 32'h1);
    tick();
    iresp_valid = 1'b0; #1;
    chk("nr.stale_ignored", {31'h0, d_valid}, 32'h0);
    chk("nr.restart_addr", ireq_addr, 32'hBFC0_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
